// File: rtl/calc_pkg.sv
// Shared definitions for the Q1.9.6 calculator datapath: op codes, limits,
// sequencer states and the saturation helpers used by the arithmetic engine.
package calc_pkg;

    localparam int W         = 16;
    localparam int FRAC      = 6;
    localparam int DIV_STEPS = W + FRAC;

    // Op codes shared with the keypad/operation FSM.
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_MUL = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4;

    localparam logic [W-1:0] Q_MAX = 16'h7FFF;
    localparam logic [W-1:0] Q_MIN = 16'h8000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_DIV_RUN,
        S_DIV_FIX,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [W-1:0] data;
        logic         ovf;
    } sat_t;

    // Clamp a wide signed intermediate into the 16-bit result range.
    function automatic sat_t sat_q(input logic signed [31:0] v);
        sat_t r;
        if (v > 32'sd32767) begin
            r = '{data: Q_MAX, ovf: 1'b1};
        end else if (v < -32'sd32768) begin
            r = '{data: Q_MIN, ovf: 1'b1};
        end else begin
            r = '{data: v[W-1:0], ovf: 1'b0};
        end
        return r;
    endfunction

    // Unsigned magnitude; 0x8000 maps to 32768, which still fits 16 unsigned bits.
    function automatic logic [W-1:0] abs_q(input logic [W-1:0] v);
        return v[W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/fixed_restoring_div.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, MSB first.
// o_done marks the cycle of the final step; o_quot is complete after that edge.
module fixed_restoring_div #(
    parameter int W     = 16,
    parameter int STEPS = 22
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             i_start,
    input  logic [STEPS-1:0] i_dividend,
    input  logic [W-1:0]     i_divisor,
    output logic             o_done,
    output logic [STEPS-1:0] o_quot
);

    localparam int CW = $clog2(STEPS);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    logic [STEPS-1:0] r_quot;
    logic [W-1:0]     r_rem;
    logic [W-1:0]     r_divisor;
    logic [CW-1:0]    r_count;
    logic             r_busy;

    logic [W:0]   w_rem_shift;
    logic         w_ge;
    logic [W-1:0] w_diff;

    // The remainder stays below the divisor, so the difference always fits W bits.
    assign w_rem_shift = {r_rem, r_quot[STEPS-1]};
    assign w_ge        = (w_rem_shift >= {1'b0, r_divisor});
    assign w_diff      = w_rem_shift[W-1:0] - r_divisor;
    assign o_done      = r_busy && (r_count == LAST);
    assign o_quot      = r_quot;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
        end else if (i_start) begin
            r_quot    <= i_dividend;
            r_rem     <= '0;
            r_divisor <= i_divisor;
            r_count   <= '0;
            r_busy    <= 1'b1;
        end else if (r_busy) begin
            r_quot  <= {r_quot[STEPS-2:0], w_ge};
            r_rem   <= w_ge ? w_diff : w_rem_shift[W-1:0];
            r_count <= r_count + 1'b1;
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fixed_alu_sequencer.sv
// Multi-cycle Q1.9.6 arithmetic engine with valid/ready handshakes on both sides;
// ADD/SUB/MUL resolve in one cycle, DIV runs through the restoring divider.
module fixed_alu_sequencer #(
    parameter int W         = 16,
    parameter int FRAC      = 6,
    parameter int DIV_STEPS = 22
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [2:0]   req_op,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [W-1:0] resp_data,
    output logic         resp_ovf,
    output logic         resp_div0,
    output logic         resp_badop,
    output logic         busy
);

    import calc_pkg::*;

    localparam logic [DIV_STEPS-1:0] POS_LIMIT = DIV_STEPS'(2 ** (W - 1) - 1);
    localparam logic [DIV_STEPS-1:0] NEG_LIMIT = DIV_STEPS'(2 ** (W - 1));

    state_t       r_state;
    logic [2:0]   r_op;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic         r_neg;
    logic [W-1:0] r_data;
    logic         r_valid;
    logic         r_ovf;
    logic         r_div0;
    logic         r_badop;

    logic signed [W:0]     w_sum;
    logic signed [2*W-1:0] w_prod;
    sat_t                  w_sum_sat;
    sat_t                  w_mul_sat;
    logic                  w_div_start;
    logic                  w_div_done;
    logic [DIV_STEPS-1:0]  w_quot;
    logic [W-1:0]          w_fix_data;
    logic                  w_fix_ovf;

    always_comb begin
        if (r_op == OP_SUB) begin
            w_sum = $signed({r_a[W-1], r_a}) - $signed({r_b[W-1], r_b});
        end else begin
            w_sum = $signed({r_a[W-1], r_a}) + $signed({r_b[W-1], r_b});
        end
        w_prod    = $signed(r_a) * $signed(r_b);
        w_sum_sat = sat_q(32'(w_sum));
        w_mul_sat = sat_q(w_prod >>> FRAC);
    end

    assign w_div_start = (r_state == S_EXEC) && (r_op == OP_DIV) && (r_b != '0);

    fixed_restoring_div #(
        .W     (W),
        .STEPS (DIV_STEPS)
    ) u_div (
        .clk        (clk),
        .clear      (clear),
        .i_start    (w_div_start),
        .i_dividend ({abs_q(r_a), {FRAC{1'b0}}}),
        .i_divisor  (abs_q(r_b)),
        .o_done     (w_div_done),
        .o_quot     (w_quot)
    );

    // NOTE: every output gets a default before the branches so no latch is inferred.
    always_comb begin
        w_fix_data = w_quot[W-1:0];
        w_fix_ovf  = 1'b0;
        if (r_neg) begin
            if (w_quot > NEG_LIMIT) begin
                w_fix_data = Q_MIN;
                w_fix_ovf  = 1'b1;
            end else begin
                w_fix_data = -w_quot[W-1:0];
            end
        end else if (w_quot > POS_LIMIT) begin
            w_fix_data = Q_MAX;
            w_fix_ovf  = 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_neg   <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_div0  <= 1'b0;
            r_badop <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op    <= req_op;
                        r_a     <= req_a;
                        r_b     <= req_b;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_ovf   <= 1'b0;
                    r_div0  <= 1'b0;
                    r_badop <= 1'b0;
                    r_valid <= 1'b1;
                    r_state <= S_DONE;
                    case (r_op)
                        OP_ADD, OP_SUB: begin
                            r_data <= w_sum_sat.data;
                            r_ovf  <= w_sum_sat.ovf;
                        end
                        OP_MUL: begin
                            r_data <= w_mul_sat.data;
                            r_ovf  <= w_mul_sat.ovf;
                        end
                        OP_DIV: begin
                            if (r_b == '0) begin
                                r_data <= '0;
                                r_div0 <= 1'b1;
                            end else begin
                                // Flags and data hold the previous result until the fix step.
                                r_ovf   <= r_ovf;
                                r_div0  <= r_div0;
                                r_badop <= r_badop;
                                r_valid <= 1'b0;
                                r_neg   <= r_a[W-1] ^ r_b[W-1];
                                r_state <= S_DIV_RUN;
                            end
                        end
                        default: begin
                            r_data  <= '0;
                            r_badop <= 1'b1;
                        end
                    endcase
                end
                S_DIV_RUN: begin
                    if (w_div_done) begin
                        r_state <= S_DIV_FIX;
                    end
                end
                S_DIV_FIX: begin
                    r_data  <= w_fix_data;
                    r_ovf   <= w_fix_ovf;
                    r_div0  <= 1'b0;
                    r_badop <= 1'b0;
                    r_valid <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (resp_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign resp_valid = r_valid;
    assign resp_data  = r_data;
    assign resp_ovf   = r_ovf;
    assign resp_div0  = r_div0;
    assign resp_badop = r_badop;

endmodule

// File: tb/tb_fixed_alu_sequencer.sv
// Directed bench for fixed_alu_sequencer: hand-computed Q1.9.6 results,
// latencies, flags, backpressure and abort-by-clear.
module tb_fixed_alu_sequencer;

    import calc_pkg::*;

    logic        clk = 1'b0;
    logic        clear;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_data;
    logic        resp_ovf;
    logic        resp_div0;
    logic        resp_badop;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    fixed_alu_sequencer dut (
        .clk        (clk),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_ovf   (resp_ovf),
        .resp_div0  (resp_div0),
        .resp_badop (resp_badop),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1);
    end

    // Issue one request, count edges until resp_valid, capture the result, then release it.
    // lat = 0 means resp_valid never rose within the bound. busy_ok tracks busy=1/req_ready=0 while waiting.
    task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          output int lat, output logic [15:0] data, output logic [2:0] flags,
                          output logic busy_ok);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = OP_ADD;
        req_a     = 16'hFFFF;
        req_b     = 16'hFFFF;
        lat       = 0;
        busy_ok   = busy && !req_ready;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (resp_valid) begin
                lat = i;
                break;
            end
            if (!busy || req_ready) busy_ok = 1'b0;
        end
        data  = resp_data;
        flags = {resp_ovf, resp_div0, resp_badop};
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({resp_valid, resp_data, resp_ovf, resp_div0, resp_badop} !== 20'h0) begin
            n_errors++;
            $display("FAIL reset_resp: got valid=%b data=%h flags=%b%b%b, expected all zero",
                     resp_valid, resp_data, resp_ovf, resp_div0, resp_badop);
        end
        n_checks++;
        if ({busy, req_ready} !== 2'b01) begin
            n_errors++;
            $display("FAIL reset_ctrl: got busy=%b req_ready=%b, expected busy=0 req_ready=1", busy, req_ready);
        end
    endtask

    task automatic test_add_sub();
        logic [15:0] exp_d [4] = '{16'h00F0, 16'hFFD0, 16'h7FFF, 16'h8000};
        logic [2:0]  exp_f [4] = '{3'b000, 3'b000, 3'b100, 3'b100};
        logic [2:0]  ops   [4] = '{OP_ADD, OP_SUB, OP_ADD, OP_SUB};
        logic [15:0] va    [4] = '{16'h0060, 16'h0060, 16'h7FFF, 16'h8000};
        logic [15:0] vb    [4] = '{16'h0090, 16'h0090, 16'h0001, 16'h0001};
        int lat; logic [15:0] d; logic [2:0] f; logic bo;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], va[i], vb[i], lat, d, f, bo);
            n_checks++;
            if (lat !== 1 || d !== exp_d[i] || f !== exp_f[i]) begin
                n_errors++;
                $display("FAIL add_sub[%0d]: got lat=%0d data=%h flags=%b, expected lat=1 data=%h flags=%b",
                         i, lat, d, f, exp_d[i], exp_f[i]);
            end
        end
    endtask

    task automatic test_mul();
        logic [15:0] exp_d [4] = '{16'h00D8, 16'h7FFF, 16'hFFA0, 16'hFFFF};
        logic [2:0]  exp_f [4] = '{3'b000, 3'b100, 3'b000, 3'b000};
        logic [15:0] va    [4] = '{16'h0060, 16'h4000, 16'hFFC0, 16'hFFFF};
        logic [15:0] vb    [4] = '{16'h0090, 16'h0200, 16'h0060, 16'h0001};
        int lat; logic [15:0] d; logic [2:0] f; logic bo;
        for (int i = 0; i < 4; i++) begin
            run_op(OP_MUL, va[i], vb[i], lat, d, f, bo);
            n_checks++;
            if (lat !== 1 || d !== exp_d[i] || f !== exp_f[i]) begin
                n_errors++;
                $display("FAIL mul[%0d]: got lat=%0d data=%h flags=%b, expected lat=1 data=%h flags=%b",
                         i, lat, d, f, exp_d[i], exp_f[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [15:0] exp_d [6] = '{16'h0060, 16'hFFA0, 16'h7FFF, 16'h8000, 16'h0015, 16'hFFEB};
        logic [2:0]  exp_f [6] = '{3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000};
        logic [15:0] va    [6] = '{16'h0090, 16'hFF70, 16'h8000, 16'h8000, 16'h0001, 16'hFFFF};
        logic [15:0] vb    [6] = '{16'h0060, 16'h0060, 16'hFFC0, 16'h0040, 16'h0003, 16'h0003};
        int lat; logic [15:0] d; logic [2:0] f; logic bo;
        for (int i = 0; i < 6; i++) begin
            run_op(OP_DIV, va[i], vb[i], lat, d, f, bo);
            n_checks++;
            if (lat !== 24 || d !== exp_d[i] || f !== exp_f[i] || bo !== 1'b1) begin
                n_errors++;
                $display("FAIL div[%0d]: got lat=%0d data=%h flags=%b busy_ok=%b, expected lat=24 data=%h flags=%b busy_ok=1",
                         i, lat, d, f, bo, exp_d[i], exp_f[i]);
            end
        end
    endtask

    task automatic test_div0_badop();
        logic [2:0]  ops   [3] = '{OP_DIV, 3'd5, 3'd0};
        logic [2:0]  exp_f [3] = '{3'b010, 3'b001, 3'b001};
        int lat; logic [15:0] d; logic [2:0] f; logic bo;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], 16'h0040, 16'h0000, lat, d, f, bo);
            n_checks++;
            if (lat !== 1 || d !== 16'h0000 || f !== exp_f[i]) begin
                n_errors++;
                $display("FAIL err_op[%0d]: got lat=%0d data=%h flags=%b, expected lat=1 data=0000 flags=%b",
                         i, lat, d, f, exp_f[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        int lat; logic [15:0] d; logic [2:0] f; logic bo;
        req_op = OP_ADD; req_a = 16'h0100; req_b = 16'h0100; req_valid = 1'b1;
        @(posedge clk); #1;
        // Keep a different request asserted; it must not be taken while the result is held.
        req_op = OP_SUB; req_a = 16'h0001; req_b = 16'h0002;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            if (resp_valid !== 1'b1 || resp_data !== 16'h0200 || req_ready !== 1'b0 || resp_ovf !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL bp_hold: got %0d unstable cycles (last valid=%b data=%h ready=%b), expected 0",
                     bad, resp_valid, resp_data, req_ready);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_data !== 16'h0200) begin
            n_errors++;
            $display("FAIL bp_release: got valid=%b ready=%b data=%h, expected valid=0 ready=1 data=0200",
                     resp_valid, req_ready, resp_data);
        end
        run_op(OP_SUB, 16'h0050, 16'h0100, lat, d, f, bo);
        n_checks++;
        if (lat !== 1 || d !== 16'hFF50 || f !== 3'b000) begin
            n_errors++;
            $display("FAIL bp_next: got lat=%0d data=%h flags=%b, expected lat=1 data=ff50 flags=000", lat, d, f);
        end
    endtask

    task automatic test_clear_abort();
        int seen = 0;
        int lat; logic [15:0] d; logic [2:0] f; logic bo;
        req_op = OP_DIV; req_a = 16'h0090; req_b = 16'h0060; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1 clear = 1'b1;
        #1;
        n_checks++;
        if ({resp_valid, resp_data, resp_ovf, resp_div0, resp_badop, busy, req_ready} !== {20'h0, 2'b01}) begin
            n_errors++;
            $display("FAIL clear_abort: got valid=%b data=%h flags=%b%b%b busy=%b ready=%b, expected zeros, ready=1",
                     resp_valid, resp_data, resp_ovf, resp_div0, resp_badop, busy, req_ready);
        end
        #1 clear = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (resp_valid || busy) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++;
            $display("FAIL clear_quiet: got %0d cycles with valid/busy after abort, expected 0", seen);
        end
        run_op(OP_ADD, 16'h0060, 16'h0090, lat, d, f, bo);
        n_checks++;
        if (lat !== 1 || d !== 16'h00F0 || f !== 3'b000) begin
            n_errors++;
            $display("FAIL clear_after: got lat=%0d data=%h flags=%b, expected lat=1 data=00f0 flags=000", lat, d, f);
        end
    endtask

    initial begin
        clear      = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        req_op     = 3'd0;
        req_a      = 16'h0000;
        req_b      = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        clear = 1'b0;
        @(posedge clk); #1;
        test_add_sub();
        test_mul();
        test_div();
        test_div0_badop();
        test_backpressure();
        test_clear_abort();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fixed_alu_sequencer.md
Name: fixed_alu_sequencer

Overview:
- Multi-cycle arithmetic engine for the Q1.9.6 calculator datapath: 16-bit two's complement, 6 fraction bits, range −512.000 … +511.984.
- Replaces the single-cycle combinational divide with a 22-step restoring divider.
- Applies saturation and error flagging to all four operations.
- Sits between the keypad/operation FSM (requester) and the display converter (consumer), with valid/ready handshakes on both sides.

Parameters:
- W, 16, operand/result width.
- FRAC, 6, fraction bits.
- DIV_STEPS, 22, divider iterations (W+FRAC).

Ports:
- clk  in  1  system clock, rising edge.
- clear  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  3  operation code: 1=ADD, 2=SUB, 3=MUL, 4=DIV; 0 and 5–7 are invalid.
- req_a  in  16  operand A, Q1.9.6.
- req_b  in  16  operand B, Q1.9.6.
- resp_valid  out  1  result held and valid.
- resp_ready  in  1  consumer takes the result.
- resp_data  out  16  result, Q1.9.6.
- resp_ovf  out  1  result saturated.
- resp_div0  out  1  divide by zero.
- resp_badop  out  1  invalid op code.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (clear high, asynchronous): state=IDLE; resp_valid=0; resp_data=0; all flags 0; busy=0; req_ready=1. Asserting clear mid-operation aborts it; no response is produced.
- req_ready = (state==IDLE). Accept occurs at an edge where req_valid && req_ready. Operands and op are registered at the accept edge.
- States: IDLE → EXEC → (DIV_RUN → DIV_FIX) → DONE → IDLE.
- EXEC, one cycle:
  - ADD/SUB: 17-bit signed sum. If outside [−32768, 32767], saturate to 0x7FFF or 0x8000 and set ovf. Go to DONE.
  - MUL: 32-bit signed product, arithmetic shift right by FRAC (floor). Saturate to 16 bits, setting ovf. Go to DONE.
  - DIV with b==0: data=0, div0=1, go to DONE.
  - DIV otherwise: load dividend=|a|<<FRAC (22 bits), divisor=|b|, remainder=0, step counter=0. Quotient sign = a[15]^b[15]. Go to DIV_RUN.
  - Invalid op: data=0, badop=1, go to DONE.
- DIV_RUN: one restoring step per cycle, MSB first; exits after DIV_STEPS cycles into DIV_FIX.
- DIV_FIX: negate the quotient if the sign bit is set. Quotient magnitude is truncated toward zero. Saturate (magnitude >32767 positive, >32768 negative), setting ovf. Go to DONE.
- Latency (edges after the accept edge until resp_valid is visible):
  - ADD/SUB/MUL/invalid op/div-by-0: 1.
  - DIV: 24 (1 setup + 22 steps + 1 fix).
- DONE: resp_valid=1. resp_data and flags stay stable until an edge with resp_ready=1, then go to IDLE with resp_valid=0. resp_data and flags keep their last value until the next result.
- No new accept during DONE (req_ready=0). Minimum spacing between accepts is 3 cycles.
- Operand edge cases:
  - |0x8000| is handled as 32768 in 17-bit magnitude.
  - 0x8000 / 0xFFC0 (−512 / −1) → 0x7FFF with ovf=1.
- Changes on req_* while busy are ignored.

Decomposition:
- Shared package calc_pkg:
  - op-code constants ADD/SUB/MUL/DIV (3-bit, matching the keypad FSM);
  - FRAC=6, W=16;
  - Q_MAX=0x7FFF, Q_MIN=0x8000;
  - state enum.
- One natural sub-module: fixed_restoring_div. It is iterative, with start/done, magnitude in, unsigned quotient out. The sequencer owns the sign and saturation logic around it.

Test Plan:
- ADD 0x0060 (1.50) + 0x0090 (2.25) → resp_data=0x00F0 (3.75), flags 0, resp_valid 1 edge after accept. SUB 0x0060−0x0090 → 0xFFD0 (−0.75).
- MUL 0x0060 × 0x0090 → 0x00D8 (3.375), 1-edge latency. MUL 0x4000 × 0x0200 → 0x7FFF, ovf=1.
- DIV 0x0090 / 0x0060 → 0x0060 (1.50) exactly 24 edges after accept. DIV 0xFF70 / 0x0060 → 0xFFA0 (−1.50). Also check busy=1 throughout and req_ready=0.
- DIV 0x0040 / 0x0000 → data 0, div0=1, latency 1. Op 5 → data 0, badop=1.
- Backpressure: hold resp_ready=0 for 10 cycles → resp_valid and data stay stable and req_ready stays 0. Then raise resp_ready → IDLE next edge, and the next request is accepted.
- Pulse clear at step 10 of a DIV → all outputs return to reset values immediately with no resp_valid. The following ADD completes normally.
